flight_mode_sequencer: RTL

Top-level flight-phase controller that sequences the motor control FSM. It debounces the arm switch (receiverCH5) and walks the craft through arm, spin-up, hover and landing. It produces the shared base throttle, the motor enable and the takeoff/landing flags consumed by the motor control FSM. It also supervises the six gyro tilt flags for sensor faults and persistent tilt.

---
 rtl/flight_pkg.sv | 46 ++++
 rtl/switch_debounce.sv | 52 +++++
 rtl/flight_mode_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/flight_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flight_pkg
// Description : Shared types and default constants for the flight-phase
//               sequencer: state encoding, tuning defaults and the ordering
//               of the six-bit gyro tilt-flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package flight_pkg;

  // Default tuning values; the top-level parameters start from these.
  localparam int DEF_THR_W        = 8;
  localparam int DEF_HOVER_THR    = 128;
  localparam int DEF_RAMP_STEP    = 4;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_ARM_HOLD     = 8;
  localparam int DEF_TILT_LIMIT   = 16;

  // Flight phases; codes 6 and 7 are illegal and recover through FAULT.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SPINUP = 3'd2,
    ST_HOVER  = 3'd3,
    ST_LAND   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Gyro bundle is packed as {X, _X, Y, _Y, Z, _Z}.
  localparam int GYRO_W  = 6;
  localparam int GYRO_XP = 5;
  localparam int GYRO_XN = 4;
  localparam int GYRO_YP = 3;
  localparam int GYRO_YN = 2;
  localparam int GYRO_ZP = 1;
  localparam int GYRO_ZN = 0;

  // A physical axis cannot tilt both ways at once: both flags high means a bad sensor.
  function automatic logic axis_contradiction(input logic [GYRO_W-1:0] g);
    return (g[GYRO_XP] & g[GYRO_XN]) |
           (g[GYRO_YP] & g[GYRO_YN]) |
           (g[GYRO_ZP] & g[GYRO_ZN]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : 2-FF synchroniser followed by a stability counter. The output
//               flips only after DEBOUNCE_CYC consecutive synchronised samples
//               disagree with it; any agreeing sample restarts the count.
//               Reusable for any receiver switch channel.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int c_cnt_w = $clog2(DEBOUNCE_CYC + 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_dout;
  logic [c_cnt_w-1:0] r_cnt;

  // Synchronise the raw input and count consecutive samples that differ from the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_dout) begin
        if (r_cnt == c_cnt_w'(DEBOUNCE_CYC - 1)) begin
          r_dout <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/flight_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flight_mode_sequencer
// Description : Flight-phase controller. Debounces the arm switch and walks
//               IDLE -> ARM -> SPINUP -> HOVER -> LAND -> IDLE, generating the
//               base throttle ramp, motor enable and takeoff/landing flags.
//               Supervises the gyro flags for contradictions (FAULT) and
//               persistent tilt (forced LAND).
// Revision    : 1.0 - initial release
// ============================================================================
module flight_mode_sequencer
  import flight_pkg::*;
#(
  parameter int THR_W        = DEF_THR_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int ARM_HOLD     = DEF_ARM_HOLD,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int HOVER_THR    = DEF_HOVER_THR,
  parameter int TILT_LIMIT   = DEF_TILT_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             receiverCH5,
  input  logic             gyroX,
  input  logic             gyro_X,
  input  logic             gyroY,
  input  logic             gyro_Y,
  input  logic             gyroZ,
  input  logic             gyro_Z,
  output logic [THR_W-1:0] throttle,
  output logic             motor_en,
  output logic             takeoff,
  output logic             landing,
  output logic             fault,
  output logic [2:0]       state
);

  localparam int             c_arm_w     = $clog2(ARM_HOLD + 1);
  localparam int             c_tilt_w    = $clog2(TILT_LIMIT + 1);
  localparam logic [THR_W:0] c_step_ext  = (THR_W+1)'(RAMP_STEP);
  localparam logic [THR_W:0] c_hover_ext = (THR_W+1)'(HOVER_THR);
  localparam logic [THR_W-1:0] c_step_thr  = THR_W'(RAMP_STEP);
  localparam logic [THR_W-1:0] c_hover_thr = THR_W'(HOVER_THR);

  state_t              r_state;
  logic [THR_W-1:0]    r_throttle;
  logic                r_motor_en;
  logic                r_takeoff;
  logic                r_landing;
  logic                r_fault;
  logic [c_arm_w-1:0]  r_arm_cnt;
  logic [c_tilt_w-1:0] r_tilt_cnt;

  logic                w_sw_db;
  logic [GYRO_W-1:0]   w_gyro;
  logic                w_contra;
  logic                w_any_tilt;
  logic                w_tilt_hit;
  logic                w_arm_done;
  logic [THR_W:0]      w_up_sum;
  logic [THR_W-1:0]    w_ramp_up;
  logic [THR_W-1:0]    w_ramp_down;
  state_t              w_next;
  logic [THR_W-1:0]    w_thr_next;

  switch_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_arm_switch (
    .clk  (clk),
    .reset(reset),
    .din  (receiverCH5),
    .dout (w_sw_db)
  );

  assign w_gyro     = {gyroX, gyro_X, gyroY, gyro_Y, gyroZ, gyro_Z};
  assign w_contra   = axis_contradiction(w_gyro);
  assign w_any_tilt = |w_gyro;
  assign w_tilt_hit = w_any_tilt && (r_tilt_cnt == c_tilt_w'(TILT_LIMIT - 1));
  assign w_arm_done = (r_arm_cnt == c_arm_w'(ARM_HOLD - 1));

  // Ramp up is done one bit wider so the clamp sees any overshoot past the hover target.
  assign w_up_sum    = {1'b0, r_throttle} + c_step_ext;
  assign w_ramp_up   = (w_up_sum > c_hover_ext) ? c_hover_thr : w_up_sum[THR_W-1:0];
  assign w_ramp_down = (r_throttle > c_step_thr) ? (r_throttle - c_step_thr) : '0;

  // Next phase and next throttle; earlier tests in each branch take priority.
  always_comb begin
    w_next     = r_state;
    w_thr_next = r_throttle;
    case (r_state)
      ST_IDLE: begin
        w_thr_next = '0;
        if (w_sw_db) w_next = ST_ARM;
      end
      ST_ARM: begin
        w_thr_next = '0;
        if (w_contra)        w_next = ST_FAULT;
        else if (!w_sw_db)   w_next = ST_IDLE;
        else if (w_arm_done) w_next = ST_SPINUP;
      end
      ST_SPINUP: begin
        w_thr_next = w_ramp_up;
        if (w_contra) begin
          w_next     = ST_FAULT;
          w_thr_next = '0;
        end else if (w_tilt_hit || !w_sw_db) begin
          w_next     = ST_LAND;
          w_thr_next = r_throttle;
        end else if (r_throttle == c_hover_thr) begin
          w_next     = ST_HOVER;
        end
      end
      ST_HOVER: begin
        w_thr_next = c_hover_thr;
        if (w_contra) begin
          w_next     = ST_FAULT;
          w_thr_next = '0;
        end else if (w_tilt_hit || !w_sw_db) begin
          w_next     = ST_LAND;
        end
      end
      ST_LAND: begin
        w_thr_next = w_ramp_down;
        if (w_contra) begin
          w_next     = ST_FAULT;
          w_thr_next = '0;
        end else if (r_throttle == '0) begin
          w_next     = ST_IDLE;
          w_thr_next = '0;
        end
      end
      ST_FAULT: begin
        w_thr_next = '0;
        if (!w_sw_db) w_next = ST_IDLE;
      end
      default: begin
        w_next     = ST_FAULT;
        w_thr_next = '0;
      end
    endcase
  end

  // Phase register, phase counters and registered outputs derived from the next phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_throttle <= '0;
      r_motor_en <= 1'b0;
      r_takeoff  <= 1'b0;
      r_landing  <= 1'b0;
      r_fault    <= 1'b0;
      r_arm_cnt  <= '0;
      r_tilt_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_throttle <= w_thr_next;
      r_motor_en <= (w_next == ST_ARM) || (w_next == ST_SPINUP) ||
                    (w_next == ST_HOVER) || (w_next == ST_LAND);
      r_takeoff  <= (w_next == ST_SPINUP);
      r_landing  <= (w_next == ST_LAND);
      r_fault    <= (w_next == ST_FAULT);

      if (w_next != r_state)
        r_arm_cnt <= '0;
      else if ((r_state == ST_ARM) && w_sw_db)
        r_arm_cnt <= r_arm_cnt + 1'b1;

      if (w_next != r_state)
        r_tilt_cnt <= '0;
      else if (((r_state == ST_SPINUP) || (r_state == ST_HOVER)) && w_any_tilt)
        r_tilt_cnt <= r_tilt_cnt + 1'b1;
      else
        r_tilt_cnt <= '0;
    end
  end

  assign throttle = r_throttle;
  assign motor_en = r_motor_en;
  assign takeoff  = r_takeoff;
  assign landing  = r_landing;
  assign fault    = r_fault;
  assign state    = r_state;

endmodule
`default_nettype wire
